z_writeback: RTL and testbench

Result stage directly downstream of the ALU. It captures the 64-bit ALU result (`ZMuxIn`) together with its operation code into the Z register. It then writes the result back over the 32-bit bus as one or two handshaked beats:
- one beat to the general-register destination for single-word ops;
- two beats (LO then HI) for `mul`/`div`.

It replaces the free-running ZLow/ZHigh bus drivers with a sequenced, back-pressurable write-back.

---
 rtl/z_writeback.sv | 119 +++++++++++
 tb/tb_z_writeback.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/z_writeback.sv
// Z result register with a sequenced, back-pressurable write-back onto the 32-bit bus.
// Optional result flags are enabled by defining ZWB_FLAGS_EN.
module z_writeback #(
  parameter int          WIDTH  = 32,
  parameter logic [4:0]  OP_MUL = 5'b01111,
  parameter logic [4:0]  OP_DIV = 5'b10000
) (
  input  logic                 clock,
  input  logic                 clear,
  input  logic [2*WIDTH-1:0]   ZMuxIn,
  input  logic [4:0]           ALUControl,
  input  logic                 Zin,
  input  logic                 wb_ready,
  output logic [WIDTH-1:0]     bus_data,
  output logic                 bus_valid,
  output logic                 gen_wr,
  output logic                 LOin,
  output logic                 HIin,
  output logic [WIDTH-1:0]     ZLow,
  output logic [WIDTH-1:0]     ZHigh,
  output logic                 busy,
  output logic                 overrun,
  output logic [1:0]           z_flags
);

  typedef enum logic [1:0] {IDLE, WB_LO, WB_HI} state_t;

  state_t             state, next_state;
  logic [2*WIDTH-1:0] z;
  logic [4:0]         op;
  logic               two_word;
  logic               final_xfer;
  logic               capture;

  assign two_word = (op == OP_MUL) || (op == OP_DIV);
  assign busy     = (state != IDLE);
  assign ZLow     = z[WIDTH-1:0];
  assign ZHigh    = z[2*WIDTH-1:WIDTH];
  // A new result is only taken when idle or when the last beat of the current one leaves.
  assign capture  = Zin && ((state == IDLE) || final_xfer);

  always_comb begin
    next_state = state;
    bus_valid  = 1'b0;
    bus_data   = '0;
    gen_wr     = 1'b0;
    LOin       = 1'b0;
    HIin       = 1'b0;
    final_xfer = 1'b0;
    case (state)
      IDLE: begin
        if (Zin) next_state = WB_LO;
      end
      WB_LO: begin
        bus_valid = 1'b1;
        bus_data  = z[WIDTH-1:0];
        if (two_word) LOin = 1'b1;
        else          gen_wr = 1'b1;
        if (wb_ready) begin
          if (two_word) begin
            next_state = WB_HI;
          end else begin
            final_xfer = 1'b1;
            next_state = Zin ? WB_LO : IDLE;
          end
        end
      end
      WB_HI: begin
        bus_valid = 1'b1;
        bus_data  = z[2*WIDTH-1:WIDTH];
        HIin      = 1'b1;
        if (wb_ready) begin
          final_xfer = 1'b1;
          next_state = Zin ? WB_LO : IDLE;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      state   <= IDLE;
      z       <= '0;
      op      <= '0;
      overrun <= 1'b0;
    end else begin
      state <= next_state;
      if (capture) begin
        z  <= ZMuxIn;
        op <= ALUControl;
      end
      if (Zin && busy && !final_xfer) overrun <= 1'b1;
    end
  end

`ifdef ZWB_FLAGS_EN
  logic [1:0] flags;
  logic       in_two_word;

  assign in_two_word = (ALUControl == OP_MUL) || (ALUControl == OP_DIV);
  assign z_flags     = flags;

  // Two-word results take sign and zero over the full 64 bits; others over the low word.
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      flags <= 2'b00;
    end else if (capture) begin
      if (in_two_word)
        flags <= {ZMuxIn[2*WIDTH-1], (ZMuxIn == '0)};
      else
        flags <= {ZMuxIn[WIDTH-1], (ZMuxIn[WIDTH-1:0] == '0)};
    end
  end
`else
  assign z_flags = 2'b00;
`endif

endmodule

// File: tb/tb_z_writeback.sv
// Self-checking bench for z_writeback: directed scenarios then random traffic against a beat-queue model.
module tb_z_writeback;

  logic        clock;
  logic        clear;
  logic [63:0] ZMuxIn;
  logic [4:0]  ALUControl;
  logic        Zin;
  logic        wb_ready;
  logic [31:0] bus_data;
  logic        bus_valid;
  logic        gen_wr;
  logic        LOin;
  logic        HIin;
  logic [31:0] ZLow;
  logic [31:0] ZHigh;
  logic        busy;
  logic        overrun;
  logic [1:0]  z_flags;

  int checks   = 0;
  int failures = 0;

  // Model: pending beats as {kind, data}; kind 0 = general reg, 1 = LO, 2 = HI.
  logic [33:0] beat_q[$];
  logic [63:0] model_z;
  logic        model_overrun;
  logic [1:0]  model_flags;

  z_writeback dut (
    .clock(clock), .clear(clear), .ZMuxIn(ZMuxIn), .ALUControl(ALUControl),
    .Zin(Zin), .wb_ready(wb_ready), .bus_data(bus_data), .bus_valid(bus_valid),
    .gen_wr(gen_wr), .LOin(LOin), .HIin(HIin), .ZLow(ZLow), .ZHigh(ZHigh),
    .busy(busy), .overrun(overrun), .z_flags(z_flags)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    beat_q.delete();
    model_z       = '0;
    model_overrun = 1'b0;
    model_flags   = 2'b00;
  endtask

  task automatic check_outputs(input string tag);
    logic        v;
    logic [33:0] f;
    v = (beat_q.size() != 0);
    f = v ? beat_q[0] : 34'd0;
    check({tag, ".valid"},   bus_valid, v);
    check({tag, ".data"},    bus_data,  v ? f[31:0] : 32'd0);
    check({tag, ".gen_wr"},  gen_wr,    v && f[33:32] == 2'd0);
    check({tag, ".LOin"},    LOin,      v && f[33:32] == 2'd1);
    check({tag, ".HIin"},    HIin,      v && f[33:32] == 2'd2);
    check({tag, ".busy"},    busy,      v);
    check({tag, ".overrun"}, overrun,   model_overrun);
    check({tag, ".ZLow"},    ZLow,      model_z[31:0]);
    check({tag, ".ZHigh"},   ZHigh,     model_z[63:32]);
    check({tag, ".flags"},   z_flags,   model_flags);
  endtask

  // Starts and ends at a falling edge; one rising edge in between.
  task automatic step(input logic zin_v, input logic ready_v,
                      input logic [63:0] data_v, input logic [4:0] op_v);
    logic had, xfer, wide;
    check_outputs("step");
    Zin = zin_v; wb_ready = ready_v; ZMuxIn = data_v; ALUControl = op_v;
    @(posedge clock);
    had  = (beat_q.size() != 0);
    xfer = had && ready_v;
    if (xfer) void'(beat_q.pop_front());
    if (zin_v) begin
      if (!had || (xfer && beat_q.size() == 0)) begin
        wide    = (op_v == 5'd15) || (op_v == 5'd16);
        model_z = data_v;
        if (wide) begin
          beat_q.push_back({2'd1, data_v[31:0]});
          beat_q.push_back({2'd2, data_v[63:32]});
        end else begin
          beat_q.push_back({2'd0, data_v[31:0]});
        end
`ifdef ZWB_FLAGS_EN
        model_flags = wide ? {data_v[63], data_v == 64'd0}
                           : {data_v[31], data_v[31:0] == 32'd0};
`endif
      end else begin
        model_overrun = 1'b1;
      end
    end
    @(negedge clock);
  endtask

  task automatic applyStimulus();
    logic [63:0] d;
    logic [4:0]  o;
    for (int i = 0; i < 400; i++) begin
      d = {$urandom, $urandom};
      case ($urandom_range(0, 7))
        0: d = 64'd0;
        1: d[31:0] = 32'd0;
        default: ;
      endcase
      case ($urandom_range(0, 3))
        0: o = 5'b01111;
        1: o = 5'b10000;
        default: o = 5'($urandom_range(0, 31));
      endcase
      step(1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0, d, o);
    end
    check_outputs("rand.end");
  endtask

  initial begin
    clock = 1'b0;
    clear = 1'b0;
    Zin = 1'b1; wb_ready = 1'b1;
    ZMuxIn = {$urandom, $urandom}; ALUControl = 5'($urandom_range(0, 31));
    model_reset();
    repeat (3) @(posedge clock);
    @(negedge clock);
    check_outputs("reset");
    check("reset.bus_data", bus_data, 32'd0);
    check("reset.busy", busy, 1'b0);
    Zin = 1'b0;
    clear = 1'b1;
    #1 check("release.busy", busy, 1'b0);
    @(negedge clock);

    // Single-word add
    step(1'b1, 1'b1, 64'h7, 5'b00011);
    check("add.data", bus_data, 32'h7);
    check("add.gen_wr", gen_wr, 1'b1);
    step(1'b0, 1'b1, 64'h0, 5'b0);
    check("add.idle", busy, 1'b0);

    // Mul held off by wb_ready for three cycles
    step(1'b1, 1'b0, 64'h0000_0001_FFFF_FFFE, 5'b01111);
    check("mul.lo0", bus_data, 32'hFFFF_FFFE);
    check("mul.LOin0", LOin, 1'b1);
    for (int i = 1; i < 4; i++) begin
      step(1'b0, 1'b0, 64'h0, 5'b0);
      check("mul.lo_hold", bus_data, 32'hFFFF_FFFE);
      check("mul.LOin_hold", LOin, 1'b1);
    end
    step(1'b0, 1'b1, 64'h0, 5'b0);
    check("mul.hi", bus_data, 32'h0000_0001);
    check("mul.HIin", HIin, 1'b1);
    step(1'b0, 1'b1, 64'h0, 5'b0);
    check("mul.idle", busy, 1'b0);

    // Back-to-back adds through the final-beat bypass
    step(1'b1, 1'b1, 64'h11, 5'b00011);
    check("b2b.first", bus_data, 32'h11);
    step(1'b1, 1'b1, 64'h22, 5'b00011);
    check("b2b.second", bus_data, 32'h22);
    check("b2b.gen_wr", gen_wr, 1'b1);
    check("b2b.overrun", overrun, 1'b0);
    step(1'b0, 1'b1, 64'h0, 5'b0);
    check("b2b.idle", busy, 1'b0);

    // Overrun while a div is stalled, then clear during the HI beat
    step(1'b1, 1'b0, 64'h0000_0003_0000_0005, 5'b10000);
    step(1'b1, 1'b0, 64'hDEAD_BEEF_0BAD_F00D, 5'b00011);
    check("ovr.flag", overrun, 1'b1);
    check("ovr.zlow", ZLow, 32'h0000_0005);
    check("ovr.zhigh", ZHigh, 32'h0000_0003);
    step(1'b0, 1'b1, 64'h0, 5'b0);
    check("ovr.hi", HIin, 1'b1);
    clear = 1'b0;
    model_reset();
    #1;
    check_outputs("clr");
    check("clr.valid", bus_valid, 1'b0);
    check("clr.overrun", overrun, 1'b0);
    clear = 1'b1;
    @(negedge clock);

    // Flag capture
    step(1'b1, 1'b1, 64'h8000_0000_0000_0000, 5'b01111);
`ifdef ZWB_FLAGS_EN
    check("flags.mul", z_flags, 2'b10);
`else
    check("flags.mul_off", z_flags, 2'b00);
`endif
    step(1'b0, 1'b1, 64'h0, 5'b0);
    step(1'b0, 1'b1, 64'h0, 5'b0);
    step(1'b1, 1'b1, 64'h1_0000_0000, 5'b00011);
`ifdef ZWB_FLAGS_EN
    check("flags.add", z_flags, 2'b01);
`else
    check("flags.add_off", z_flags, 2'b00);
`endif
    step(1'b0, 1'b1, 64'h0, 5'b0);

    applyStimulus();

    $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
    $finish;
  end

endmodule
